// File: rtl/receptor_jogada_serial_pkg.sv
// ---------------------------------------------------------------------------
// receptor_jogada_serial_pkg
// Shared definitions for the remote-player serial receiver:
//   - estado_rx_t    : receiver FSM encoding, also the value shown on db_estado
//   - estado_saida_t : output (button press) FSM encoding
//   - ASCII_1/ASCII_9: range of accepted move characters
//   - PULSE_CYCLES_PADRAO: default press length / release gap in clocks
//   - eh_digito()    : true for a byte in the ASCII_1..ASCII_9 range
// ---------------------------------------------------------------------------
package receptor_jogada_serial_pkg;

    // PARIDADE keeps its code even when the parity frame is not built, so the
    // hex display values stay the same in both configurations.
    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        INICIO     = 4'd1,
        DADOS      = 4'd2,
        PARIDADE   = 4'd3,
        PARADA     = 4'd4,
        DECODIFICA = 4'd5
    } estado_rx_t;

    typedef enum logic [1:0] {
        LIVRE     = 2'd0,
        PULSO     = 2'd1,
        INTERVALO = 2'd2
    } estado_saida_t;

    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_9 = 8'h39;

    localparam int PULSE_CYCLES_PADRAO = 1_000_000;

    function automatic logic eh_digito(input logic [7:0] c);
        return (c >= ASCII_1) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/receptor_jogada_serial_if.sv
// ---------------------------------------------------------------------------
// receptor_jogada_serial_if
// Bundle of the receiver's functional signals (clock and reset stay plain).
//   rx                 : UART line, idle high, asynchronous to the clock
//   habilita           : 1 = moves accepted, 0 = decoded digits discarded
//   botoes[8:0]        : one-hot button press vector to the game circuit
//   jogada_valida      : 1-cycle pulse, digit accepted
//   caractere_invalido : 1-cycle pulse, well-framed non-digit byte
//   erro_quadro        : 1-cycle pulse, bad stop (or parity) bit
//   overrun            : 1-cycle pulse, digit dropped with holding full
//   db_estado[3:0]     : receiver FSM state for the hex display
// Modports: slave = the receiver, master = whoever drives rx/habilita.
// ---------------------------------------------------------------------------
interface receptor_jogada_serial_if;

    logic       rx;
    logic       habilita;
    logic [8:0] botoes;
    logic       jogada_valida;
    logic       caractere_invalido;
    logic       erro_quadro;
    logic       overrun;
    logic [3:0] db_estado;

    modport slave (
        input  rx,
        input  habilita,
        output botoes,
        output jogada_valida,
        output caractere_invalido,
        output erro_quadro,
        output overrun,
        output db_estado
    );

    modport master (
        output rx,
        output habilita,
        input  botoes,
        input  jogada_valida,
        input  caractere_invalido,
        input  erro_quadro,
        input  overrun,
        input  db_estado
    );

endinterface

// File: rtl/receptor_jogada_serial_contador_baud.sv
// ---------------------------------------------------------------------------
// contador_baud
// Free-running bit-period counter for the UART receiver.
//   clock, reset : system clock, asynchronous active-low reset
//   i_limpa      : forces the count back to 0
//   o_meio       : high on the last clock of a half period (DIV/2 clocks
//                  after a clear)
//   o_fim        : high on the last clock of a full period (DIV clocks after
//                  a clear); the counter wraps by itself on that clock
// ---------------------------------------------------------------------------
module contador_baud #(
    parameter int DIV = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic i_limpa,
    output logic o_meio,
    output logic o_fim
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cont;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cont <= '0;
        end else if (i_limpa || o_fim) begin
            r_cont <= '0;
        end else begin
            r_cont <= r_cont + CW'(1);
        end
    end

    assign o_meio = (r_cont == CW'(DIV / 2 - 1));
    assign o_fim  = (r_cont == CW'(DIV - 1));

endmodule

// File: rtl/receptor_jogada_serial.sv
// ---------------------------------------------------------------------------
// receptor_jogada_serial
// Remote-player front end: receives UART characters, turns ASCII '1'..'9'
// into a one-hot 9-bit button press of PULSE_CYCLES clocks followed by a
// release gap of PULSE_CYCLES clocks.
//   clock : system clock
//   reset : asynchronous, active-low
//   bus   : receptor_jogada_serial_if.slave (rx, habilita in; botoes,
//           jogada_valida, caractere_invalido, erro_quadro, overrun,
//           db_estado out)
// Parameters: CLK_FREQ, BAUD (DIV = CLK_FREQ/BAUD), PULSE_CYCLES.
// Build option: RECEPTOR_PARIDADE_EN selects an 8E1 frame (even parity bit
// checked after the data bits); undefined gives plain 8N1.
// ---------------------------------------------------------------------------
module receptor_jogada_serial
    import receptor_jogada_serial_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int PULSE_CYCLES = PULSE_CYCLES_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    receptor_jogada_serial_if.slave  bus
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CWP = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    // -----------------------------------------------------------------------
    // rx synchronizer plus one extra flop for falling-edge detection. Reset
    // to 1 (idle line) so leaving reset never looks like a start bit.
    // -----------------------------------------------------------------------
    logic r_rxMeta, r_rxSync, r_rxAnt;
    logic w_borda;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxAnt  <= 1'b1;
        end else begin
            r_rxMeta <= bus.rx;
            r_rxSync <= r_rxMeta;
            r_rxAnt  <= r_rxSync;
        end
    end

    // Needs a high-then-low sequence, so after a framing error with the
    // line still low the receiver only re-arms once the line returns high.
    assign w_borda = r_rxAnt & ~r_rxSync;

    // -----------------------------------------------------------------------
    // Receiver FSM
    // -----------------------------------------------------------------------
    estado_rx_t r_estRx, w_proxRx;
    logic [2:0] r_bitCnt;
    logic [7:0] r_desloc;
    logic       w_limpa, w_amostra, w_erroQuadro, w_meio, w_fim;

    contador_baud #(.DIV(DIV)) u_contadorBaud (
        .clock   (clock),
        .reset   (reset),
        .i_limpa (w_limpa),
        .o_meio  (w_meio),
        .o_fim   (w_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estRx  <= OCIOSO;
            r_bitCnt <= '0;
            r_desloc <= '0;
        end else begin
            r_estRx <= w_proxRx;
            if (w_amostra) begin
                r_desloc <= {r_rxSync, r_desloc[7:1]};
                r_bitCnt <= r_bitCnt + 3'd1;
            end else if (r_estRx != DADOS) begin
                r_bitCnt <= '0;
            end
        end
    end

    // The baud counter is held clear while idle and re-cleared at the middle
    // of the start bit, so every later full-period tick lands mid-bit.
    always_comb begin
        w_proxRx     = r_estRx;
        w_limpa      = 1'b0;
        w_amostra    = 1'b0;
        w_erroQuadro = 1'b0;
        case (r_estRx)
            OCIOSO: begin
                w_limpa = 1'b1;
                if (w_borda) w_proxRx = INICIO;
            end
            INICIO: begin
                if (w_meio) begin
                    w_limpa  = 1'b1;
                    w_proxRx = r_rxSync ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (w_fim) begin
                    w_amostra = 1'b1;
                    if (r_bitCnt == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
                        w_proxRx = PARIDADE;
`else
                        w_proxRx = PARADA;
`endif
                    end
                end
            end
`ifdef RECEPTOR_PARIDADE_EN
            PARIDADE: begin
                if (w_fim) begin
                    if (^{r_desloc, r_rxSync}) begin
                        w_erroQuadro = 1'b1;
                        w_proxRx     = OCIOSO;
                    end else begin
                        w_proxRx = PARADA;
                    end
                end
            end
`endif
            PARADA: begin
                if (w_fim) begin
                    if (r_rxSync) begin
                        w_proxRx = DECODIFICA;
                    end else begin
                        w_erroQuadro = 1'b1;
                        w_proxRx     = OCIOSO;
                    end
                end
            end
            DECODIFICA: w_proxRx = OCIOSO;
            default:    w_proxRx = OCIOSO;
        endcase
    end

    // -----------------------------------------------------------------------
    // Decode (only meaningful during the single DECODIFICA cycle)
    // -----------------------------------------------------------------------
    logic       w_decod, w_digitoAceito, w_caractereInvalido;
    logic [3:0] w_indiceNovo;

    assign w_decod             = (r_estRx == DECODIFICA);
    assign w_digitoAceito      = w_decod &  eh_digito(r_desloc) & bus.habilita;
    assign w_caractereInvalido = w_decod & ~eh_digito(r_desloc);
    // '1'..'9' have low nibble 1..9, so the button index is that minus one.
    assign w_indiceNovo        = r_desloc[3:0] - 4'd1;

    // -----------------------------------------------------------------------
    // Holding register and output FSM
    // -----------------------------------------------------------------------
    estado_saida_t   r_estSaida, w_proxSaida;
    logic [CWP-1:0]  r_contPulso;
    logic [3:0]      r_indice, r_indiceSaida;
    logic            r_cheio;
    logic            w_fimPulso, w_podeCarregar, w_carga, w_desvio;
    logic            w_escreve, w_overrun;

    assign w_fimPulso = (r_contPulso == CWP'(PULSE_CYCLES - 1));

    // A new press may start while idle or on the last gap cycle; the latter
    // keeps the release gap exactly PULSE_CYCLES when a move is waiting.
    assign w_podeCarregar = (r_estSaida == LIVRE) |
                            ((r_estSaida == INTERVALO) & w_fimPulso);
    assign w_carga   = w_podeCarregar & (r_cheio | w_digitoAceito);
    // Empty holding register and output ready: the digit goes straight to
    // the output stage without being parked, so the press starts next cycle.
    assign w_desvio  = w_podeCarregar & ~r_cheio & w_digitoAceito;
    assign w_escreve = w_digitoAceito & (~r_cheio | w_podeCarregar);
    assign w_overrun = w_digitoAceito &  r_cheio & ~w_podeCarregar;

    // Write and drain in the same cycle: the output takes the old entry and
    // the new one lands, so the full flag simply stays set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cheio  <= 1'b0;
            r_indice <= '0;
        end else if (w_escreve && !w_desvio) begin
            r_cheio  <= 1'b1;
            r_indice <= w_indiceNovo;
        end else if (w_podeCarregar && r_cheio) begin
            r_cheio  <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estSaida    <= LIVRE;
            r_contPulso   <= '0;
            r_indiceSaida <= '0;
        end else begin
            r_estSaida <= w_proxSaida;
            if ((r_estSaida == LIVRE) || (w_proxSaida != r_estSaida)) begin
                r_contPulso <= '0;
            end else begin
                r_contPulso <= r_contPulso + CWP'(1);
            end
            if (w_carga) begin
                r_indiceSaida <= r_cheio ? r_indice : w_indiceNovo;
            end
        end
    end

    always_comb begin
        w_proxSaida = r_estSaida;
        case (r_estSaida)
            LIVRE:     if (w_carga)    w_proxSaida = PULSO;
            PULSO:     if (w_fimPulso) w_proxSaida = INTERVALO;
            INTERVALO: if (w_fimPulso) w_proxSaida = w_carga ? PULSO : LIVRE;
            default:   w_proxSaida = LIVRE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: all derived from registered state, so reset clears them at once
    // -----------------------------------------------------------------------
    assign bus.botoes             = (r_estSaida == PULSO) ? (9'd1 << r_indiceSaida) : 9'd0;
    assign bus.jogada_valida      = w_escreve;
    assign bus.caractere_invalido = w_caractereInvalido;
    assign bus.erro_quadro        = w_erroQuadro;
    assign bus.overrun            = w_overrun;
    assign bus.db_estado          = r_estRx;

endmodule
